// File: rtl/lpf_fir_dec3_pkg.sv
// Shared widths, coefficient set and helpers for the 11-tap symmetric
// anti-alias FIR that precedes the decimate-by-3 stage.
package lpf_fir_dec3_pkg;

  localparam int NTAPS   = 11;
  localparam int LATENCY = 5;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PRE_W  = 17;
  localparam int PROD_W = 33;
  localparam int PSUM_W = 34;
  localparam int ACC_W  = 36;

  localparam int NPAIRS = 5;
  localparam int NPROD  = 6;
  localparam int NPSUM  = 3;
  localparam int CENTRE = 5;

  // Number of register stages from data_in capture to data_out.
  localparam int PIPE_DEPTH = 5;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PRE_W-1:0]  pre_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Q1.15 coefficients; h(10-k) equals h(k), so only six are unique.
  localparam coef_t COEF_H0 = -16'sd256;
  localparam coef_t COEF_H1 = 16'sd0;
  localparam coef_t COEF_H2 = 16'sd1536;
  localparam coef_t COEF_H3 = 16'sd4096;
  localparam coef_t COEF_H4 = 16'sd6912;
  localparam coef_t COEF_H5 = 16'sd8192;

  function automatic coef_t coef(input int idx);
    coef_t c;
    case (idx)
      0:       c = COEF_H0;
      1:       c = COEF_H1;
      2:       c = COEF_H2;
      3:       c = COEF_H3;
      4:       c = COEF_H4;
      default: c = COEF_H5;
    endcase
    return c;
  endfunction

  function automatic pre_t sext_pre(input sample_t s);
    return pre_t'(s);
  endfunction

endpackage

// File: rtl/round_sat_36to16.sv
// Final pipeline stage: round-half-up the Q1.15-scaled accumulator to an
// integer sample and clamp it into the signed 16-bit range.
module round_sat_36to16
  import lpf_fir_dec3_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [DATA_W-1:0] data_out
);

  localparam int SHIFT   = 15;
  localparam int SHR_W   = ACC_W + 1 - SHIFT;

  localparam logic signed [ACC_W:0]   ROUND_BIAS = (ACC_W+1)'(1 << (SHIFT - 1));
  localparam logic signed [SHR_W-1:0] SAT_MAX    = SHR_W'(32767);
  localparam logic signed [SHR_W-1:0] SAT_MIN    = -SHR_W'(32768);

  logic signed [ACC_W:0]    rounded;
  logic signed [SHR_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat_d;

  // One guard bit on the bias add; dropping the low bits is the arithmetic shift.
  always_comb begin
    rounded = (ACC_W+1)'(acc_in) + ROUND_BIAS;
    shifted = rounded[ACC_W:SHIFT];
    if (shifted > SAT_MAX) begin
      sat_d = DATA_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      sat_d = DATA_W'(SAT_MIN);
    end else begin
      sat_d = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else begin
      data_out <= sat_d;
    end
  end

endmodule

// File: rtl/lpf_fir_dec3.sv
// 11-tap symmetric low-pass FIR at full input rate: delay line, pre-add,
// multiply, two adder levels and round/saturate, one sample per clock.
module lpf_fir_dec3
  import lpf_fir_dec3_pkg::*;
#(
  parameter int NTAPS   = lpf_fir_dec3_pkg::NTAPS,
  parameter int LATENCY = lpf_fir_dec3_pkg::LATENCY
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] data_out
);

  if (NTAPS != 11) begin : g_ntaps_unsupported
    $error("lpf_fir_dec3: only NTAPS = 11 is supported");
  end

  if (LATENCY != PIPE_DEPTH) begin : g_latency_note
    $warning("lpf_fir_dec3: LATENCY parameter does not describe the fixed pipeline");
  end

  logic [NTAPS-1:0][DATA_W-1:0] taps_q;

  pre_t  pre_d  [NPROD];
  pre_t  pre_q  [NPROD];
  prod_t prod_d [NPROD];
  prod_t prod_q [NPROD];
  psum_t psum_d [NPSUM];
  psum_t psum_q [NPSUM];
  acc_t  acc_d;
  acc_t  acc_q;

  // Tap 0 holds the newest sample; reset holds the whole line at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
    end else begin
      taps_q <= {taps_q[NTAPS-2:0], data_in};
    end
  end

  for (genvar k = 0; k < NPAIRS; k++) begin : g_pre
    assign pre_d[k] = sext_pre(sample_t'(taps_q[k])) +
                      sext_pre(sample_t'(taps_q[NTAPS-1-k]));
  end
  assign pre_d[CENTRE] = sext_pre(sample_t'(taps_q[CENTRE]));

  for (genvar k = 0; k < NPROD; k++) begin : g_mul
    assign prod_d[k] = prod_t'(pre_q[k]) * prod_t'(coef(k));
  end

  for (genvar j = 0; j < NPSUM; j++) begin : g_psum
    assign psum_d[j] = psum_t'(prod_q[2*j]) + psum_t'(prod_q[2*j+1]);
  end

  // Two extra bits over the partial sums make the three-way add overflow-free.
  assign acc_d = acc_t'(psum_q[0]) + acc_t'(psum_q[1]) + acc_t'(psum_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '{default: '0};
      prod_q <= '{default: '0};
      psum_q <= '{default: '0};
      acc_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      prod_q <= prod_d;
      psum_q <= psum_d;
      acc_q  <= acc_d;
    end
  end

  round_sat_36to16 u_round_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_in   (acc_q),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_lpf_fir_dec3.sv
// Self-checking bench for lpf_fir_dec3: directed impulse/step/reset/saturation
// tables plus random samples against a plain-arithmetic convolution model.
module tb_lpf_fir_dec3;

  typedef struct {
    int din;
    int expout;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] data_in;
  logic signed [15:0] data_out;

  int tests  = 0;
  int failed = 0;

  int h [11] = '{-256, 0, 1536, 4096, 6912, 8192, 6912, 4096, 1536, 0, -256};
  int ramp [11] = '{-128, -128, 640, 2688, 6144, 10240, 13696, 15744, 16512, 16512, 16384};
  int impulse_resp [11] = '{-128, 0, 768, 2048, 3456, 4096, 3456, 2048, 768, 0, -128};

  int hist [11];
  int ydly [5];
  int exp_now;

  vec_t tbl [$];
  int   dec_dut [$];
  int   dec_ref [$];

  always #5 clk = ~clk;

  lpf_fir_dec3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_out (data_out)
  );

  function automatic int ref_filter();
    longint acc = 0;
    for (int k = 0; k < 11; k++) acc += longint'(h[k]) * longint'(hist[k]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 11; k++) hist[k] = 0;
    for (int k = 0; k < 5; k++) ydly[k] = 0;
    exp_now = 0;
  endtask

  // Drive on the falling edge; the model sees what the DUT captured on the rising edge.
  task automatic applyStimulus(input int din);
    @(negedge clk);
    data_in = 16'(din);
    @(posedge clk);
    if (rst_n) begin
      exp_now = ydly[4];
      for (int k = 4; k > 0; k--) ydly[k] = ydly[k-1];
      for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(data_in);
      ydly[0] = ref_filter();
    end else begin
      exp_now = 0;
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input int expected);
    tests++;
    if (int'(data_out) != expected) begin
      failed++;
      $display("[TB] FAIL %s: data_out=%0d expected=%0d", name, int'(data_out), expected);
    end
  endtask

  function automatic void add_vec(input int din, input int expout);
    vec_t v;
    v.din    = din;
    v.expout = expout;
    tbl.push_back(v);
  endfunction

  initial begin
    int pat [11];
    int phase;

    // Impulse (17 edges) followed by step (22 edges), outputs from the spec tables.
    for (int i = 0; i < 17; i++)
      add_vec((i == 0) ? 16384 : 0, (i >= 5 && i <= 15) ? impulse_resp[i-5] : 0);
    for (int i = 0; i < 22; i++)
      add_vec(16384, (i < 5) ? 0 : ((i - 5) <= 10 ? ramp[i-5] : 16384));

    rst_n   = 1'b0;
    data_in = '0;
    model_reset();
    #12;
    checkOutput("reset_state", 0);
    applyStimulus(1234);
    checkOutput("reset_ignores_input0", 0);
    applyStimulus(-777);
    checkOutput("reset_ignores_input1", 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].din);
      checkOutput($sformatf("table[%0d]", i), tbl[i].expout);
    end

    // Asynchronous reset mid-cycle while the step is settled, then replay the ramp.
    applyStimulus(16384);
    checkOutput("step_settled", 16384);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("reset_async_immediate", 0);
    applyStimulus(16384);
    checkOutput("reset_hold0", 0);
    applyStimulus(16384);
    checkOutput("reset_hold1", 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(16384);
      checkOutput($sformatf("post_reset_ramp[%0d]", i),
                  (i < 5) ? 0 : ((i - 5) <= 10 ? ramp[i-5] : 16384));
    end

    // Coefficient-signed extremes drive the sum beyond 16-bit range.
    for (int k = 0; k < 11; k++) pat[k] = (h[k] > 0) ? 32767 : ((h[k] < 0) ? -32768 : 0);
    for (int k = 0; k < 11; k++) applyStimulus(pat[k]);
    for (int j = 0; j < 5; j++) applyStimulus(0);
    checkOutput("sat_positive", 32767);

    for (int k = 0; k < 11; k++) pat[k] = (h[k] > 0) ? -32768 : ((h[k] < 0) ? 32767 : 0);
    for (int k = 0; k < 11; k++) applyStimulus(pat[k]);
    for (int j = 0; j < 5; j++) applyStimulus(0);
    checkOutput("sat_negative", -32768);

    phase = 0;
    for (int i = 0; i < 10000; i++) begin
      int r;
      case ($urandom_range(7))
        0:       r = 32767;
        1:       r = -32768;
        default: r = int'($signed(16'($urandom())));
      endcase
      applyStimulus(r);
      checkOutput($sformatf("random[%0d]", i), exp_now);
      if (phase == 0) begin
        dec_dut.push_back(int'(data_out));
        dec_ref.push_back(exp_now);
      end
      phase = (phase == 2) ? 0 : phase + 1;
    end

    for (int i = 0; i < dec_ref.size(); i++) begin
      tests++;
      if (dec_dut[i] != dec_ref[i]) begin
        failed++;
        $display("[TB] FAIL decim3[%0d]: data_out=%0d expected=%0d", i, dec_dut[i], dec_ref[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lpf_fir_dec3.md
LPF_FIR_DEC3 -- requirements
Module: lpf_fir_dec3

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  sample clock; the block SHALL accept one sample per rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 data_in  input  16  signed two's-complement input sample (I or Q path of the DDC, post-mixer).
REQ-005 data_out  output  16  signed two's-complement low-pass-filtered sample, registered, full input rate; feeds the decimate-by-3 stage.
REQ-006 Parameter NTAPS, default 11, meaning filter length; the only supported value SHALL be 11.
REQ-007 Parameter LATENCY, default 5, meaning clocks from data_in capture to first data_out contribution; it SHALL be informational only.

Function
REQ-008 The block SHALL implement an 11-tap symmetric FIR anti-alias filter, y[n] = sum h[k]*x[n-k], for k = 0..10.
REQ-009 Coefficients SHALL be Q1.15 signed: h0=h10=-256, h1=h9=0, h2=h8=1536, h3=h7=4096, h4=h6=6912, h5=8192; their sum is 32768 (unity DC gain).
REQ-010 Delay line: 11 x 16-bit registers; data_in SHALL be captured into tap 0 on every rising clk edge, with no enable and no bypass.
REQ-011 Stage 1 (pre-add): for each of the 5 symmetric pairs, x[k]+x[10-k] SHALL be sign-extended to 17 bits; the centre tap x[5] SHALL be sign-extended to 17 bits; the result SHALL be registered.
REQ-012 Stage 2 (multiply): each 17-bit pre-sum SHALL be multiplied by its 16-bit coefficient into a 33-bit signed product, which SHALL be registered.
REQ-013 Stage 3 (partial sums): the 6 products SHALL be summed pairwise into 3 registered 34-bit sums.
REQ-014 Stage 4 (final sum): the 3 partial sums SHALL be summed into one registered 36-bit accumulator, with no overflow possible.
REQ-015 Stage 5 (round/saturate): the block SHALL add 2^14, arithmetic-shift right 15, and saturate to [-32768, 32767]; the result SHALL be registered into data_out.
REQ-016 Latency: a sample captured at edge n SHALL first affect data_out at edge n+5; throughput SHALL be 1 sample/clock with no stalls.
REQ-017 Saturation SHALL clamp symmetrically: results above 32767 SHALL give 32767, and results below -32768 SHALL give -32768; wrap-around is forbidden.
REQ-018 The block SHALL have no state machine and no handshake; all pipeline stages SHALL advance on every clock.

Reset
REQ-019 On rst_n low, the block SHALL asynchronously clear all delay-line, pipeline and data_out registers to 0, regardless of clk.
REQ-020 While rst_n is low, data_out SHALL be 0, and data_in SHALL be ignored.
REQ-021 After rst_n deasserts mid-stream, data_out SHALL equal the response of a zero-initialised filter, with no residue from pre-reset samples.
REQ-022 The first post-reset data_in capture SHALL occur on the first rising clk edge with rst_n high.

Structure
REQ-023 Package lpf_fir_dec3_pkg SHALL hold NTAPS, LATENCY, the data/pre-add/product/accumulator widths (16/17/33/36) and the 6 unique coefficient constants.
REQ-024 One sub-module, round_sat_36to16, SHALL implement stage 5: 36-bit input, 16-bit registered output, clk/rst_n.
REQ-025 The block SHALL contain no RAM and no vendor DSP primitives; inferred multipliers SHALL be allowed.

Verification
REQ-026 Scenario 1 (impulse): data_in=16384 for one clock, else 0 -> data_out at edges n+5..n+15 SHALL be -128, 0, 768, 2048, 3456, 4096, 3456, 2048, 768, 0, -128, then 0.
REQ-027 Scenario 2 (step): data_in held at 16384 -> data_out SHALL settle at exactly 16384 from edge n+15 onward.
REQ-028 Scenario 3 (positive saturation): 11 samples signed to match coefficient signs (+32767 where h>0, -32768 where h<0, 0 at h1/h9) -> data_out SHALL be 32767, not wrapped.
REQ-029 Scenario 4 (negative saturation): the inverse pattern of scenario 3 -> data_out SHALL be -32768.
REQ-030 Scenario 5 (reset mid-stream): step at 16384, rst_n pulsed low for 2 clocks asynchronously mid-cycle -> data_out SHALL be 0 immediately, then SHALL replay the scenario-2 ramp from the first edge after release.
REQ-031 Scenario 6 (random vectors): 10000 random samples -> data_out SHALL match a bit-exact reference model with the same rounding and saturation, at 5-clock alignment; it SHALL be checked both with and without a following decimate-by-3 stage.
